b_t_encoder: RTL and testbench

Binary-to-temporal encoder. It is the upstream stage that produces the temporal "select" line for the temporal-to-binary mux.
- Accepts binary time codes through a valid/ready handshake and buffers them in a small FIFO.
- In each gamma cycle it emits at most one rising edge, at the offset equal to the code, and holds it for up to PULSE_WIDTH cycles.
- Its gamma counter runs in lockstep with downstream counters because all share aclk/grst.

---
 rtl/b_t_pkg.sv | 27 ++
 rtl/b_t_fifo.sv | 54 +++++
 rtl/b_t_encoder.sv | 120 ++++++++++++
 tb/tb_b_t_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/b_t_pkg.sv
// Shared types and width helpers for the binary-to-temporal encoder.
package b_t_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } b_t_state_e;

  localparam int GAMMA_DEFAULT = 16;
  localparam int PULSE_DEFAULT = 8;
  localparam int FIFO_DEFAULT  = 2;

  // Gamma counter width and pulse-counter width (must hold PULSE_WIDTH itself).
  localparam int CNT_W_DEFAULT  = $clog2(GAMMA_DEFAULT);
  localparam int PCNT_W_DEFAULT = $clog2(PULSE_DEFAULT + 1);

  function automatic int cnt_w(input int gamma);
    return $clog2(gamma);
  endfunction

  function automatic int pcnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/b_t_fifo.sv
// Small synchronous FIFO buffering time codes; async active-high reset.
module b_t_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic                       aclk,
  input  logic                       grst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/b_t_encoder.sv
// Binary-to-temporal encoder: one pulse per gamma cycle at the buffered code's offset.
// Optional macro NULL_CODE_EN: code G-1 means "no spike" for that gamma cycle.
module b_t_encoder
  import b_t_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
  parameter int PULSE_WIDTH       = PULSE_DEFAULT,
  parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH),
  parameter int FIFO_DEPTH        = FIFO_DEFAULT
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out,
  output logic                   gamma_start,
  output logic                   busy
);

  localparam int CW = cnt_w(GAMMA_CYCLE_WIDTH);
  localparam int PW = pcnt_w(PULSE_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  b_t_state_e             state, state_next;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          pcnt, pcnt_next;
  logic [VALUE_WIDTH-1:0] active_value, active_next;
  logic [VALUE_WIDTH-1:0] head;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  b_t_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VALUE_WIDTH)
  ) u_fifo (
    .aclk    (aclk),
    .grst    (grst),
    .push    (in_valid && in_ready),
    .pop     (pop),
    .wr_data (in_value),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready    = !fifo_full;
  assign gamma_start = (cnt == '0);
  assign busy        = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // The boundary load overrides every state, so a pulse never spans two gammas.
  always_comb begin
    state_next  = state;
    pcnt_next   = pcnt;
    active_next = active_value;
    pop         = 1'b0;
    if (cnt == LAST) begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        active_next = head;
        if (head == '0) begin
          state_next = PULSE;
          pcnt_next  = PW'(1);
`ifdef NULL_CODE_EN
        end else if (head == '1) begin
          state_next = DONE;
`endif
        end else begin
          state_next = WAIT;
        end
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state)
        WAIT: begin
          if (({1'b0, cnt} + 1'b1) == {1'b0, active_value}) begin
            state_next = PULSE;
            pcnt_next  = PW'(1);
          end
        end
        PULSE: begin
          if (pcnt == PW'(PULSE_WIDTH)) begin
            state_next = DONE;
          end else begin
            pcnt_next = pcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // out is registered from the next state, so it equals (state == PULSE) with no comb path.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state        <= IDLE;
      pcnt         <= '0;
      active_value <= '0;
      out          <= 1'b0;
    end else begin
      state        <= state_next;
      pcnt         <= pcnt_next;
      active_value <= active_next;
      out          <= (state_next == PULSE);
    end
  end

endmodule

// File: tb/tb_b_t_encoder.sv
// Self-checking bench for b_t_encoder: code scoreboard plus per-cycle output model.
module tb_b_t_encoder;

  localparam int G     = 16;
  localparam int PWID  = 8;
  localparam int VW    = 4;
  localparam int DEPTH = 2;

  logic          aclk = 1'b0;
  logic          grst;
  logic [VW-1:0] in_value;
  logic          in_valid;
  logic          in_ready;
  logic          out;
  logic          gamma_start;
  logic          busy;

  int exp_q[$];
  int mcnt;
  int armed;
  bit armed_v;
  bit accepted;
  int checks = 0;
  int errors = 0;

  b_t_encoder #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (PWID),
    .VALUE_WIDTH       (VW),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .in_value    (in_value),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .gamma_start (gamma_start),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check_output(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (model cnt %0d, t=%0t)", tag, act, exp, mcnt, $time);
    end
  endtask

  function automatic int expected_out();
    bit hit;
    hit = armed_v && (mcnt >= armed) && (mcnt <= armed + PWID - 1);
`ifdef NULL_CODE_EN
    if (armed == G - 1) hit = 1'b0;
`endif
    return int'(hit);
  endfunction

  task automatic compare_all();
    check_output("out", int'(out), expected_out());
    check_output("gamma_start", int'(gamma_start), int'(mcnt == 0));
    check_output("in_ready", int'(in_ready), int'(exp_q.size() < DEPTH));
    check_output("busy", int'(busy), int'(armed_v || (exp_q.size() > 0)));
  endtask

  // One clock: model acceptance/boundary load at the posedge, compare at the negedge.
  task automatic tick();
    bit acc;
    int v;
    acc = in_valid && (exp_q.size() < DEPTH);
    v   = int'(in_value);
    @(posedge aclk);
    if (mcnt == G - 1) begin
      if (exp_q.size() > 0) begin
        armed   = exp_q.pop_front();
        armed_v = 1'b1;
      end else begin
        armed_v = 1'b0;
      end
    end
    accepted = acc;
    if (acc) exp_q.push_back(v);
    mcnt = (mcnt + 1) % G;
    @(negedge aclk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_stimulus(input int v);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_value = VW'(v);
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = accepted;
    end
    in_valid = 1'b0;
    if (!done) check_output("push_timeout", 0, 1);
  endtask

  // Run until the model counter hits c (and, if code >= 0, that code is armed).
  task automatic run_until(input int c, input int code);
    bit hit;
    hit = (mcnt == c) && (code < 0 || (armed_v && armed == code));
    for (int i = 0; i < 80 && !hit; i++) begin
      tick();
      hit = (mcnt == c) && (code < 0 || (armed_v && armed == code));
    end
    if (!hit) check_output("wait_timeout", 0, 1);
  endtask

  initial begin
    grst     = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    mcnt     = 0;
    armed    = 0;
    armed_v  = 1'b0;
    accepted = 1'b0;
    repeat (2) @(negedge aclk);
    check_output("rst_out", int'(out), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_gamma_start", int'(gamma_start), 1);
    grst = 1'b0;

    $display("[TB] idle gammas after reset");
    idle(20);

    $display("[TB] code 5 pushed at counter 3");
    run_until(3, -1);
    apply_stimulus(5);
    idle(40);

    $display("[TB] code 12 truncated at the boundary");
    apply_stimulus(12);
    idle(40);

    $display("[TB] codes 2, 7, 9 back-to-back");
    apply_stimulus(2);
    apply_stimulus(7);
    apply_stimulus(9);
    idle(60);

    $display("[TB] codes 0 and 15 in consecutive gammas");
    apply_stimulus(0);
    apply_stimulus(15);
    idle(50);

    $display("[TB] reset during a pulse");
    apply_stimulus(4);
    apply_stimulus(6);
    run_until(8, 4);
    check_output("pre_reset_out", int'(out), 1);
    #2 grst = 1'b1;
    #1;
    check_output("async_rst_out", int'(out), 0);
    check_output("async_rst_busy", int'(busy), 0);
    check_output("async_rst_in_ready", int'(in_ready), 1);
    check_output("async_rst_gamma_start", int'(gamma_start), 1);
    exp_q.delete();
    armed_v = 1'b0;
    mcnt    = 0;
    @(negedge aclk);
    grst = 1'b0;
    idle(40);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
